// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared command, opcode and engine-state types for the QSPI command engine
package qspi_pkg;

    typedef enum logic [1:0] {
        CMD_RESET   = 2'd0,
        CMD_POWERUP = 2'd1,
        CMD_READ    = 2'd2
    } cmd_t;

    localparam logic [7:0] OP_RESET     = 8'h66;
    localparam logic [7:0] OP_POWERUP   = 8'hAB;
    localparam logic [7:0] OP_READ_QUAD = 8'hEB;
    localparam logic [7:0] OP_READ_SPI  = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_DESELECT
    } eng_state_t;

endpackage

// File: rtl/qspi_sck_gen.sv
// rtl/qspi_sck_gen.sv - two-phase sck generator with drive/sample strobes at the end of phase 1
module qspi_sck_gen (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic drive_stb,
    output logic sample_stb
);

    logic phase;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            phase <= 1'b0;
        end else begin
            phase <= ~phase;
        end
    end

    assign sck        = phase;
    // Both strobes fire on the edge that closes phase 1: io_in is captured and the next bit is launched.
    assign drive_stb  = en & phase;
    assign sample_stb = en & phase;

endmodule

// File: rtl/qspi_cmd_engine.sv
// rtl/qspi_cmd_engine.sv - QSPI opcode/address/dummy serializer and read-data deserializer
// Build option: QSPI_QUAD_EN selects quad-I/O read (0xEB); otherwise single-bit read (0x0B).
module qspi_cmd_engine
    import qspi_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DUMMY      = 6,
    parameter int READ_BYTES = 4,
    parameter int CS_HIGH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  cmd_t              cmd_in,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              busy,
    output logic              cmd_done,
    output logic              cnt_done,
    output logic [7:0]        rdata,
    output logic              rvalid,
    output logic              sck,
    output logic              cs_n,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe,
    input  logic [3:0]        io_in
);

    localparam int M_A     = (ADDR_W > 8 * READ_BYTES) ? ADDR_W : 8 * READ_BYTES;
    localparam int M_B     = (DUMMY > CS_HIGH) ? DUMMY : CS_HIGH;
    localparam int M_C     = (M_A > M_B) ? M_A : M_B;
    localparam int CNT_MAX = (M_C > 8) ? M_C : 8;
    localparam int CW      = $clog2(CNT_MAX + 1);

`ifdef QSPI_QUAD_EN
    localparam logic [7:0] OP_READ   = OP_READ_QUAD;
    localparam int         UW        = 4;
    localparam int         UPB       = 2;
    localparam logic [3:0] ADDR_OE   = 4'hF;
    localparam logic [3:0] DUMMY_OE  = 4'h0;
    localparam logic [3:0] DUMMY_OUT = 4'h0;
    localparam logic [3:0] DATA_OE   = 4'h0;
    localparam logic [3:0] DATA_OUT  = 4'h0;

    function automatic logic [3:0] addr_unit(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: 4];
    endfunction
`else
    localparam logic [7:0] OP_READ   = OP_READ_SPI;
    localparam int         UW        = 1;
    localparam int         UPB       = 8;
    localparam logic [3:0] ADDR_OE   = 4'b1101;
    localparam logic [3:0] DUMMY_OE  = 4'b1101;
    localparam logic [3:0] DUMMY_OUT = 4'b1100;
    localparam logic [3:0] DATA_OE   = 4'b1100;
    localparam logic [3:0] DATA_OUT  = 4'b1100;

    function automatic logic [3:0] addr_unit(input logic [ADDR_W-1:0] a);
        return {3'b110, a[ADDR_W-1]};
    endfunction
`endif

    localparam int AW_UNITS   = ADDR_W / UW;
    localparam int DATA_UNITS = READ_BYTES * UPB;

    eng_state_t        state;
    cmd_t              cmd_q;
    logic [7:0]        op_sr;
    logic [7:0]        op_new;
    logic [ADDR_W-1:0] addr_sr;
    logic [CW-1:0]     cnt;
    logic [2:0]        sub;
    logic [7:0]        rx;
    logic [7:0]        rx_next;
    logic              drive_stb;
    logic              sample_stb;
    logic              enter_des;
    logic              pulse_done;

    qspi_sck_gen u_sck_gen (
        .clk        (clk),
        .rst        (rst),
        .en         (~cs_n),
        .sck        (sck),
        .drive_stb  (drive_stb),
        .sample_stb (sample_stb)
    );

`ifdef QSPI_QUAD_EN
    assign rx_next = {rx[3:0], io_in};
`else
    logic unused_io;
    assign unused_io = ^{io_in[3:2], io_in[0]};
    assign rx_next   = {rx[6:0], io_in[1]};
`endif

    always_comb begin
        case (cmd_in)
            CMD_RESET:   op_new = OP_RESET;
            CMD_POWERUP: op_new = OP_POWERUP;
            default:     op_new = OP_READ;
        endcase
    end

    // Deselect is entered after the last opcode bit (non-read) or the last data sample (read).
    always_comb begin
        enter_des = 1'b0;
        if (state == ST_OPCODE && drive_stb && cnt == '0 && cmd_q != CMD_READ) enter_des = 1'b1;
        if (state == ST_DATA && sample_stb && cnt == '0) enter_des = 1'b1;
        pulse_done = (enter_des && CS_HIGH == 1) || (state == ST_DESELECT && cnt == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cmd_q    <= CMD_RESET;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            cmd_done <= 1'b0;
            cnt_done <= 1'b0;
            rdata    <= 8'h00;
            rvalid   <= 1'b0;
            io_out   <= 4'h0;
            io_oe    <= 4'h0;
            op_sr    <= 8'h00;
            addr_sr  <= '0;
            cnt      <= '0;
            sub      <= 3'd0;
            rx       <= 8'h00;
        end else begin
            rvalid   <= 1'b0;
            cmd_done <= pulse_done && cmd_q != CMD_READ;
            cnt_done <= pulse_done && cmd_q == CMD_READ;
            case (state)
                ST_IDLE: begin
                    if (cmd_we) begin
                        state   <= ST_OPCODE;
                        cmd_q   <= cmd_in;
                        addr_sr <= addr_in;
                        busy    <= 1'b1;
                        cs_n    <= 1'b0;
                        io_oe   <= 4'b1101;
                        io_out  <= {3'b110, op_new[7]};
                        op_sr   <= {op_new[6:0], 1'b0};
                        cnt     <= CW'(7);
                    end
                end
                ST_OPCODE: begin
                    if (drive_stb) begin
                        if (cnt != '0) begin
                            io_out <= {3'b110, op_sr[7]};
                            op_sr  <= {op_sr[6:0], 1'b0};
                            cnt    <= cnt - CW'(1);
                        end else if (cmd_q == CMD_READ) begin
                            state   <= ST_ADDR;
                            io_oe   <= ADDR_OE;
                            io_out  <= addr_unit(addr_sr);
                            addr_sr <= addr_sr << UW;
                            cnt     <= CW'(AW_UNITS - 1);
                        end
                    end
                end
                ST_ADDR: begin
                    if (drive_stb) begin
                        if (cnt != '0) begin
                            io_out  <= addr_unit(addr_sr);
                            addr_sr <= addr_sr << UW;
                            cnt     <= cnt - CW'(1);
                        end else if (DUMMY > 0) begin
                            state  <= ST_DUMMY;
                            io_oe  <= DUMMY_OE;
                            io_out <= DUMMY_OUT;
                            cnt    <= CW'(DUMMY - 1);
                        end else begin
                            state  <= ST_DATA;
                            io_oe  <= DATA_OE;
                            io_out <= DATA_OUT;
                            cnt    <= CW'(DATA_UNITS - 1);
                            sub    <= 3'd0;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (drive_stb) begin
                        if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else begin
                            state  <= ST_DATA;
                            io_oe  <= DATA_OE;
                            io_out <= DATA_OUT;
                            cnt    <= CW'(DATA_UNITS - 1);
                            sub    <= 3'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (sample_stb) begin
                        rx <= rx_next;
                        if (sub == 3'(UPB - 1)) begin
                            sub    <= 3'd0;
                            rdata  <= rx_next;
                            rvalid <= 1'b1;
                        end else begin
                            sub <= sub + 3'd1;
                        end
                        if (cnt != '0) cnt <= cnt - CW'(1);
                    end
                end
                ST_DESELECT: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (enter_des) begin
                state  <= ST_DESELECT;
                cs_n   <= 1'b1;
                io_oe  <= 4'h0;
                io_out <= 4'h0;
                cnt    <= CW'(CS_HIGH - 1);
            end
        end
    end

endmodule

// File: tb/tb_qspi_cmd_engine.sv
// tb/tb_qspi_cmd_engine.sv - directed self-checking bench for qspi_cmd_engine with a cycle-level flash model
module tb_qspi_cmd_engine;
    import qspi_pkg::*;

`ifdef QSPI_QUAD_EN
    localparam int         A_SCK  = 6;
    localparam int         U_BYTE = 2;
    localparam logic [7:0] OP_RD  = 8'hEB;
`else
    localparam int         A_SCK  = 24;
    localparam int         U_BYTE = 8;
    localparam logic [7:0] OP_RD  = 8'h0B;
`endif
    localparam int DS    = 8 + A_SCK + 6;
    localparam int TOTAL = DS + 4 * U_BYTE;

    logic        clk = 1'b0;
    logic        rst;
    cmd_t        cmd_in;
    logic        cmd_we;
    logic [23:0] addr_in;
    logic        busy, cmd_done, cnt_done, rvalid, sck, cs_n;
    logic [7:0]  rdata;
    logic [3:0]  io_out, io_oe, io_in;

    qspi_cmd_engine dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_in   (cmd_in),
        .cmd_we   (cmd_we),
        .addr_in  (addr_in),
        .busy     (busy),
        .cmd_done (cmd_done),
        .cnt_done (cnt_done),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .sck      (sck),
        .cs_n     (cs_n),
        .io_out   (io_out),
        .io_oe    (io_oe),
        .io_in    (io_in)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] fdata [4];

    int          sck_cnt, n_rx, n_cmd_done, n_cnt_done, cmd_done_cyc, cnt_done_cyc;
    int          oe_err, both_err, cs_low, first_low, last_low, t0, idle_cyc;
    logic [7:0]  op_cap;
    logic [23:0] addr_cap;
    logic [7:0]  rx_bytes [4];
    logic        rst_cs, rst_busy;

    task automatic mon_clear();
        sck_cnt = 0; n_rx = 0; n_cmd_done = 0; n_cnt_done = 0; cmd_done_cyc = -1; cnt_done_cyc = -1;
        oe_err = 0; both_err = 0; cs_low = 0; first_low = -1; last_low = -1;
        op_cap = 8'h00; addr_cap = 24'h0; rst_cs = 1'bx; rst_busy = 1'bx;
        for (int i = 0; i < 4; i++) rx_bytes[i] = 8'hxx;
    endtask

    // Advance to the next falling edge, observe pins, and act as the flash for the coming rising edge.
    task automatic tick();
        int k, j;
        logic [7:0] b;
        @(negedge clk);
        cyc++;
        if (cmd_done && cnt_done) both_err++;
        if (cmd_done) begin n_cmd_done++; cmd_done_cyc = cyc; end
        if (cnt_done) begin n_cnt_done++; cnt_done_cyc = cyc; end
        if (rvalid) begin if (n_rx < 4) rx_bytes[n_rx] = rdata; n_rx++; end
        if (!cs_n) begin cs_low++; if (first_low < 0) first_low = cyc; last_low = cyc; end
        io_in = 4'h0;
        if (!cs_n && sck) begin
            k = sck_cnt;
            sck_cnt++;
            if (k < 8) begin
                op_cap = {op_cap[6:0], io_out[0]};
                if (io_oe !== 4'b1101 || io_out[3:2] !== 2'b11) oe_err++;
            end else if (k < 8 + A_SCK) begin
`ifdef QSPI_QUAD_EN
                addr_cap = {addr_cap[19:0], io_out};
                if (io_oe !== 4'hF) oe_err++;
`else
                addr_cap = {addr_cap[22:0], io_out[0]};
                if (io_oe !== 4'b1101) oe_err++;
`endif
            end else if (k < DS) begin
`ifdef QSPI_QUAD_EN
                if (io_oe !== 4'h0) oe_err++;
`else
                if (io_oe !== 4'b1101 || io_out[0] !== 1'b0) oe_err++;
`endif
            end else begin
                j = k - DS;
                b = fdata[(j / U_BYTE) % 4];
`ifdef QSPI_QUAD_EN
                io_in = (j % 2 == 0) ? b[7:4] : b[3:0];
                if (io_oe !== 4'h0) oe_err++;
`else
                io_in = {2'b00, b[7 - (j % 8)], 1'b0};
                if (io_oe !== 4'b1100) oe_err++;
`endif
            end
        end
    endtask

    task automatic do_cmd(input cmd_t c, input logic [23:0] a, input int we_at, input int rst_at);
        int n;
        mon_clear();
        t0 = cyc;
        cmd_in = c; addr_in = a; cmd_we = 1'b1;
        tick();
        cmd_we = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            if (cyc - t0 == we_at) begin cmd_in = CMD_RESET; addr_in = 24'hFFFFFF; cmd_we = 1'b1; end
            if (cyc - t0 == rst_at) rst = 1'b1;
            tick();
            cmd_we = 1'b0;
            if (rst) begin rst = 1'b0; rst_cs = cs_n; rst_busy = busy; end
            n++;
        end
        idle_cyc = cyc;
        checks++;
        if (busy) begin errors++; $display("FAIL cmd_timeout: busy still %0b after %0d cycles, expected 0", busy, n); end
    endtask

    task automatic check_read(input string tag);
        checks++; if (op_cap !== OP_RD) begin errors++; $display("FAIL %s_opcode: got %0h expected %0h", tag, op_cap, OP_RD); end
        checks++; if (n_rx !== 4) begin errors++; $display("FAIL %s_nbytes: got %0d expected 4", tag, n_rx); end
        checks++; if ({rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]} !== 32'hA55A00FF) begin
            errors++; $display("FAIL %s_data: got %h%h%h%h expected a55a00ff", tag, rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]); end
        checks++; if (sck_cnt !== TOTAL) begin errors++; $display("FAIL %s_sck: got %0d expected %0d", tag, sck_cnt, TOTAL); end
        checks++; if (n_cnt_done !== 1 || n_cmd_done !== 0) begin
            errors++; $display("FAIL %s_done: cnt_done %0d cmd_done %0d expected 1 0", tag, n_cnt_done, n_cmd_done); end
        checks++; if (cnt_done_cyc - t0 !== 2 * TOTAL + 2) begin
            errors++; $display("FAIL %s_done_time: got %0d expected %0d", tag, cnt_done_cyc - t0, 2 * TOTAL + 2); end
        checks++; if (idle_cyc - t0 !== 2 * TOTAL + 3) begin
            errors++; $display("FAIL %s_idle_time: got %0d expected %0d", tag, idle_cyc - t0, 2 * TOTAL + 3); end
        checks++; if (oe_err !== 0 || both_err !== 0) begin
            errors++; $display("FAIL %s_pins: oe errors %0d, both-done %0d expected 0 0", tag, oe_err, both_err); end
    endtask

    task automatic test_reset();
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
        checks++; if ({sck, busy, cmd_done, cnt_done, rvalid, rdata, io_out, io_oe} !== 21'h0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", {sck, busy, cmd_done, cnt_done, rvalid, rdata, io_out, io_oe}); end
    endtask

    task automatic test_reset_cmd();
        do_cmd(CMD_RESET, 24'h0, -1, -1);
        checks++; if (op_cap !== 8'h66) begin errors++; $display("FAIL rstcmd_opcode: got %0h expected 66", op_cap); end
        checks++; if (first_low - t0 !== 1 || last_low - t0 !== 16 || cs_low !== 16) begin
            errors++; $display("FAIL rstcmd_cs_window: first %0d last %0d count %0d expected 1 16 16", first_low - t0, last_low - t0, cs_low); end
        checks++; if (sck_cnt !== 8) begin errors++; $display("FAIL rstcmd_sck: got %0d expected 8", sck_cnt); end
        checks++; if (n_cmd_done !== 1 || cmd_done_cyc - t0 !== 18) begin
            errors++; $display("FAIL rstcmd_done: count %0d at %0d expected 1 at 18", n_cmd_done, cmd_done_cyc - t0); end
        checks++; if (idle_cyc - t0 !== 19) begin errors++; $display("FAIL rstcmd_idle: got %0d expected 19", idle_cyc - t0); end
        checks++; if (n_cnt_done !== 0 || oe_err !== 0) begin
            errors++; $display("FAIL rstcmd_misc: cnt_done %0d oe errors %0d expected 0 0", n_cnt_done, oe_err); end
    endtask

    task automatic test_read();
        do_cmd(CMD_READ, 24'h123456, -1, -1);
        check_read("read_123456");
        checks++; if (addr_cap !== 24'h123456) begin errors++; $display("FAIL read_addr: got %h expected 123456", addr_cap); end
        do_cmd(CMD_READ, 24'h000001, -1, -1);
        check_read("read_000001");
        checks++; if (addr_cap !== 24'h000001) begin errors++; $display("FAIL read_addr_low: got %h expected 000001", addr_cap); end
    endtask

    task automatic test_cmd_we_busy();
        do_cmd(CMD_READ, 24'h123456, 30, -1);
        check_read("busy_we");
        checks++; if (addr_cap !== 24'h123456) begin errors++; $display("FAIL busy_we_addr: got %h expected 123456", addr_cap); end
    endtask

    task automatic test_rst_in_data();
        do_cmd(CMD_READ, 24'h123456, -1, 2 * DS + 5);
        checks++; if (rst_cs !== 1'b1 || rst_busy !== 1'b0) begin
            errors++; $display("FAIL rst_data_state: cs_n %b busy %b expected 1 0", rst_cs, rst_busy); end
        checks++; if (n_cnt_done !== 0 || n_cmd_done !== 0) begin
            errors++; $display("FAIL rst_data_done: cnt_done %0d cmd_done %0d expected 0 0", n_cnt_done, n_cmd_done); end
        do_cmd(CMD_POWERUP, 24'h0, -1, -1);
        checks++; if (op_cap !== 8'hAB || n_cmd_done !== 1 || cmd_done_cyc - t0 !== 18) begin
            errors++; $display("FAIL rst_then_powerup: opcode %0h cmd_done %0d at %0d expected ab 1 18", op_cap, n_cmd_done, cmd_done_cyc - t0); end
    endtask

    task automatic test_back_to_back();
        int pu_last;
        do_cmd(CMD_POWERUP, 24'h0, -1, -1);
        pu_last = last_low;
        checks++; if (n_cmd_done !== 1 || op_cap !== 8'hAB) begin
            errors++; $display("FAIL b2b_powerup: cmd_done %0d opcode %0h expected 1 ab", n_cmd_done, op_cap); end
        do_cmd(CMD_READ, 24'h123456, -1, -1);
        check_read("b2b_read");
        checks++; if (first_low - pu_last - 1 !== 3) begin
            errors++; $display("FAIL b2b_cs_gap: got %0d expected 3", first_low - pu_last - 1); end
    endtask

    initial begin
        fdata[0] = 8'hA5; fdata[1] = 8'h5A; fdata[2] = 8'h00; fdata[3] = 8'hFF;
        rst = 1'b1; cmd_we = 1'b0; cmd_in = CMD_RESET; addr_in = 24'h0; io_in = 4'h0;
        mon_clear();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_reset_cmd();
        test_read();
        test_cmd_we_busy();
        test_rst_in_data();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
